// File: rtl/qr_matrix_streamer.sv
// Ping-pong row buffer feeding the QR core with gap-free ROWS-beat matrix bursts.
// Optional QRS_IDLE_ZERO_EN: drive out_1..out_4 to zero whenever valid is low.
module qr_matrix_streamer #(
    parameter int DATA_W = 17,
    parameter int ROWS   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data_1,
    input  logic [DATA_W-1:0] ld_data_2,
    input  logic [DATA_W-1:0] ld_data_3,
    input  logic [DATA_W-1:0] ld_data_4,
    output logic              valid,
    output logic [DATA_W-1:0] out_1,
    output logic [DATA_W-1:0] out_2,
    output logic [DATA_W-1:0] out_3,
    output logic [DATA_W-1:0] out_4,
    output logic              sof,
    output logic [1:0]        buf_cnt
);

    localparam int RW  = $clog2(ROWS);
    localparam int ROW_W = 4 * DATA_W;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [ROW_W-1:0]  mem [0:1][0:ROWS-1];

    logic [1:0]        full_reg;
    logic [1:0]        full_next;
    logic              wr_bank_reg;
    logic [RW-1:0]     wr_row_reg;
    logic              rd_bank_reg;
    logic [RW-1:0]     rd_row_reg;
    logic [0:0]        state_reg;
    logic              valid_reg;
    logic              sof_reg;
    logic [ROW_W-1:0]  out_row_reg;

    logic [DATA_W-1:0] ld_col  [4];
    logic [DATA_W-1:0] out_col [4];
    logic [ROW_W-1:0]  ld_row;
    logic [ROW_W-1:0]  rd_data;
    logic              accept;
    logic              wr_last;
    logic              rd_last;

    assign ld_col[0] = ld_data_1;
    assign ld_col[1] = ld_data_2;
    assign ld_col[2] = ld_data_3;
    assign ld_col[3] = ld_data_4;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cols
            assign ld_row[gi*DATA_W +: DATA_W] = ld_col[gi];
            assign out_col[gi]                 = out_row_reg[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign out_1 = out_col[0];
    assign out_2 = out_col[1];
    assign out_3 = out_col[2];
    assign out_4 = out_col[3];

    assign ld_ready = !full_reg[wr_bank_reg];
    assign accept   = ld_valid && ld_ready;
    assign wr_last  = accept && (wr_row_reg == LAST_ROW);
    assign rd_last  = (state_reg == STREAM) && (rd_row_reg == LAST_ROW);
    assign valid    = valid_reg;
    assign sof      = sof_reg;
    assign buf_cnt  = {1'b0, full_reg[0]} + {1'b0, full_reg[1]};

    // The write side only touches a non-full bank and the read side only a full
    // one, so the set and clear below can never target the same bank.
    always_comb begin
        full_next = full_reg;
        if (rd_last) begin
            full_next[rd_bank_reg] = 1'b0;
        end
        if (wr_last) begin
            full_next[wr_bank_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_bank_reg][wr_row_reg] <= ld_row;
        end
    end

    // rd_row is 0 whenever the FSM sits in IDLE, so one read port serves both states.
    assign rd_data = mem[rd_bank_reg][rd_row_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg    <= 2'b00;
            wr_bank_reg <= 1'b0;
            wr_row_reg  <= '0;
        end else begin
            full_reg <= full_next;
            if (accept) begin
                if (wr_row_reg == LAST_ROW) begin
                    wr_row_reg  <= '0;
                    wr_bank_reg <= ~wr_bank_reg;
                end else begin
                    wr_row_reg <= wr_row_reg + ROW_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            rd_bank_reg <= 1'b0;
            rd_row_reg  <= '0;
            valid_reg   <= 1'b0;
            sof_reg     <= 1'b0;
            out_row_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (full_reg[rd_bank_reg]) begin
                        state_reg   <= STREAM;
                        valid_reg   <= 1'b1;
                        sof_reg     <= 1'b1;
                        out_row_reg <= rd_data;
                        rd_row_reg  <= ROW_ONE;
                    end else begin
                        valid_reg <= 1'b0;
                        sof_reg   <= 1'b0;
`ifdef QRS_IDLE_ZERO_EN
                        out_row_reg <= '0;
`endif
                    end
                end
                STREAM: begin
                    valid_reg   <= 1'b1;
                    sof_reg     <= 1'b0;
                    out_row_reg <= rd_data;
                    // After the last row, IDLE decides on the next edge whether the
                    // other bank continues the burst back-to-back.
                    if (rd_row_reg == LAST_ROW) begin
                        rd_row_reg  <= '0;
                        rd_bank_reg <= ~rd_bank_reg;
                        state_reg   <= IDLE;
                    end else begin
                        rd_row_reg <= rd_row_reg + ROW_ONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                    sof_reg   <= 1'b0;
                end
            endcase
        end
    end

endmodule
